// File: rtl/microcode_pkg.sv
// Shared constants and helpers for the EDiC microcode sequencer.
// Holds default widths, special control/opcode values, flag positions and decode-address packing.
package microcode_pkg;

  localparam int DEF_INSTR_W = 8;
  localparam int DEF_STEP_W  = 3;
  localparam int DEF_FLAG_W  = 4;
  localparam int DEF_CTRL_W  = 24;
  localparam int DEF_CNT_W   = 16;

  localparam int                         DEF_FIN_BIT    = 20;
  localparam logic [DEF_INSTR_W-1:0]     DEF_IRQ_OPCODE = 8'hFF;
  localparam logic [DEF_CTRL_W-1:0]      DEF_CTRL_SAFE  = '1;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam int DEF_ADDR_W = DEF_FLAG_W + DEF_INSTR_W + DEF_STEP_W;

  function automatic logic [DEF_ADDR_W-1:0] packDecodeAddr(
    input logic [DEF_FLAG_W-1:0]  flags,
    input logic [DEF_INSTR_W-1:0] instr,
    input logic [DEF_STEP_W-1:0]  step
  );
    return {flags, instr, step};
  endfunction

endpackage

// File: rtl/microcode_sequencer.sv
// Microcode step sequencer: forms the decode-ROM address from opcode, flags and step,
// and passes the ROM word out as the control word, with IRQ injection and overflow fault.
module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int                   INSTR_W    = DEF_INSTR_W,
  parameter int                   STEP_W     = DEF_STEP_W,
  parameter int                   FLAG_W     = DEF_FLAG_W,
  parameter int                   CTRL_W     = DEF_CTRL_W,
  parameter int                   FIN_BIT    = DEF_FIN_BIT,
  parameter logic [INSTR_W-1:0]   IRQ_OPCODE = INSTR_W'(DEF_IRQ_OPCODE),
  parameter logic [CTRL_W-1:0]    CTRL_SAFE  = {CTRL_W{1'b1}},
  parameter int                   CNT_W      = DEF_CNT_W
) (
  input  logic                              i_nclk,
  input  logic                              i_reset,
  input  logic [INSTR_W-1:0]                i_instrCode,
  input  logic [FLAG_W-1:0]                 i_flags,
  input  logic                              i_halt,
  input  logic                              i_irq,
  output logic [FLAG_W+INSTR_W+STEP_W-1:0]  o_decodeAddr,
  input  logic [CTRL_W-1:0]                 i_decodeData,
  output logic [CTRL_W-1:0]                 o_ctrl,
  output logic [INSTR_W-1:0]                o_instr,
  output logic                              o_irqAck,
  output logic                              o_fault,
  output logic [CNT_W-1:0]                  o_retired,
  output logic [STEP_W-1:0]                 o_dbgStep
);

  logic [STEP_W-1:0]  step_q;
  logic [INSTR_W-1:0] instr_q;
  logic [FLAG_W-1:0]  flags_q;
  logic [CNT_W-1:0]   retired_q;
  logic               irqPending_q;
  logic               irqActive_q;
  logic               irqAck_q;
  logic               fault_q;

  logic finish;
  logic accept;

  // The finish bit is active-low; an IRQ is only taken at an instruction boundary.
  assign finish = ~i_decodeData[FIN_BIT];
  assign accept = finish & irqPending_q & ~i_halt & ~fault_q;

  always_ff @(posedge i_nclk) begin
    if (i_reset) begin
      step_q       <= '0;
      instr_q      <= '0;
      flags_q      <= '0;
      retired_q    <= '0;
      irqPending_q <= 1'b0;
      irqActive_q  <= 1'b0;
      irqAck_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      irqPending_q <= (irqPending_q & ~accept) | i_irq;
      irqAck_q     <= accept;
      if (i_halt || fault_q) begin
        step_q <= step_q;
      end else if (finish) begin
        step_q      <= '0;
        flags_q     <= '0;
        retired_q   <= retired_q + 1'b1;
        instr_q     <= accept ? IRQ_OPCODE : i_instrCode;
        irqActive_q <= accept;
      end else if (&step_q) begin
        // Running past the last step means the microprogram lost its finish bit.
        fault_q <= 1'b1;
      end else begin
        step_q  <= step_q + 1'b1;
        flags_q <= i_flags;
        instr_q <= irqActive_q ? IRQ_OPCODE : i_instrCode;
      end
    end
  end

  assign o_decodeAddr = {flags_q, instr_q, step_q};
  assign o_ctrl       = fault_q ? CTRL_SAFE : i_decodeData;
  assign o_instr      = instr_q;
  assign o_irqAck     = irqAck_q;
  assign o_fault      = fault_q;
  assign o_retired    = retired_q;
  assign o_dbgStep    = step_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed self-checking bench for microcode_sequencer; a tiny ROM model finishes
// the microprogram at a chosen step so each scenario can hand-predict the state.
module tb_microcode_sequencer;
  import microcode_pkg::*;

  localparam logic [23:0] RUNW = 24'h1ABCDE;
  localparam logic [23:0] FINW = 24'h0ABCDE;

  logic        i_nclk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_instrCode = 8'h00;
  logic [3:0]  i_flags = 4'h0;
  logic        i_halt = 1'b0;
  logic        i_irq = 1'b0;
  logic [14:0] o_decodeAddr;
  logic [23:0] i_decodeData;
  logic [23:0] o_ctrl;
  logic [7:0]  o_instr;
  logic        o_irqAck;
  logic        o_fault;
  logic [15:0] o_retired;
  logic [2:0]  o_dbgStep;

  int finishAt = 8;
  int compared = 0;
  int mismatched = 0;

  microcode_sequencer dut (
    .i_nclk       (i_nclk),
    .i_reset      (i_reset),
    .i_instrCode  (i_instrCode),
    .i_flags      (i_flags),
    .i_halt       (i_halt),
    .i_irq        (i_irq),
    .o_decodeAddr (o_decodeAddr),
    .i_decodeData (i_decodeData),
    .o_ctrl       (o_ctrl),
    .o_instr      (o_instr),
    .o_irqAck     (o_irqAck),
    .o_fault      (o_fault),
    .o_retired    (o_retired),
    .o_dbgStep    (o_dbgStep)
  );

  always #5 i_nclk = ~i_nclk;

  // ROM model: the finish bit drops at the chosen step, otherwise a running word.
  assign i_decodeData = (int'(o_dbgStep) == finishAt) ? FINW : RUNW;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge i_nclk);
      #1;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    finishAt = 8;
    tick(2);
    i_reset = 1'b0;
    compared++;
    if (o_decodeAddr !== 15'h0) begin mismatched++; $display("[TB] FAIL reset_addr got %h want %h", o_decodeAddr, 15'h0); end
    compared++;
    if ({o_irqAck, o_fault, o_retired, o_instr} !== 26'h0) begin mismatched++; $display("[TB] FAIL reset_state got ack=%b fault=%b ret=%h instr=%h want all 0", o_irqAck, o_fault, o_retired, o_instr); end
    compared++;
    if (o_ctrl !== RUNW) begin mismatched++; $display("[TB] FAIL reset_ctrl got %h want %h", o_ctrl, RUNW); end
  endtask

  task automatic test_basic();
    i_instrCode = 8'h12;
    finishAt = 2;
    tick();
    compared++;
    if (o_decodeAddr !== packDecodeAddr(4'h0, 8'h12, 3'd1)) begin mismatched++; $display("[TB] FAIL basic_step1 got %h want %h", o_decodeAddr, packDecodeAddr(4'h0, 8'h12, 3'd1)); end
    tick();
    compared++;
    if (o_decodeAddr !== packDecodeAddr(4'h0, 8'h12, 3'd2) || o_ctrl !== FINW) begin mismatched++; $display("[TB] FAIL basic_step2 got addr=%h ctrl=%h want addr=%h ctrl=%h", o_decodeAddr, o_ctrl, packDecodeAddr(4'h0, 8'h12, 3'd2), FINW); end
    tick();
    compared++;
    if (o_dbgStep !== 3'd0 || o_retired !== 16'd1) begin mismatched++; $display("[TB] FAIL basic_finish got step=%0d ret=%0d want step=0 ret=1", o_dbgStep, o_retired); end
  endtask

  task automatic test_flags();
    i_flags = 4'b0101;
    tick();
    compared++;
    if (o_decodeAddr[14:11] !== 4'b0101) begin mismatched++; $display("[TB] FAIL flags_latched got %b want 0101", o_decodeAddr[14:11]); end
    tick(2);
    compared++;
    if (o_decodeAddr[14:11] !== 4'b0000 || o_retired !== 16'd2) begin mismatched++; $display("[TB] FAIL flags_cleared got flags=%b ret=%0d want flags=0000 ret=2", o_decodeAddr[14:11], o_retired); end
    i_flags = 4'h0;
  endtask

  task automatic test_irq();
    finishAt = 3;
    tick();
    i_irq = 1'b1;
    tick();
    i_irq = 1'b0;
    compared++;
    if (o_irqAck !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_early_ack got %b want 0", o_irqAck); end
    tick(2);
    compared++;
    if (o_instr !== 8'hFF || o_irqAck !== 1'b1 || o_dbgStep !== 3'd0 || o_retired !== 16'd3) begin mismatched++; $display("[TB] FAIL irq_accept got instr=%h ack=%b step=%0d ret=%0d want FF 1 0 3", o_instr, o_irqAck, o_dbgStep, o_retired); end
    i_instrCode = 8'h34;
    tick();
    compared++;
    if (o_instr !== 8'hFF || o_irqAck !== 1'b0 || o_dbgStep !== 3'd1) begin mismatched++; $display("[TB] FAIL irq_hold_opcode got instr=%h ack=%b step=%0d want FF 0 1", o_instr, o_irqAck, o_dbgStep); end
    tick(3);
    compared++;
    if (o_instr !== 8'h34 || o_irqAck !== 1'b0 || o_retired !== 16'd4) begin mismatched++; $display("[TB] FAIL irq_return got instr=%h ack=%b ret=%0d want 34 0 4", o_instr, o_irqAck, o_retired); end
  endtask

  task automatic test_halt();
    finishAt = 2;
    tick(2);
    i_halt = 1'b1;
    tick(3);
    compared++;
    if (o_dbgStep !== 3'd2 || o_retired !== 16'd4 || o_ctrl !== FINW) begin mismatched++; $display("[TB] FAIL halt_frozen got step=%0d ret=%0d ctrl=%h want 2 4 %h", o_dbgStep, o_retired, o_ctrl, FINW); end
    i_halt = 1'b0;
    tick();
    compared++;
    if (o_dbgStep !== 3'd0 || o_retired !== 16'd5) begin mismatched++; $display("[TB] FAIL halt_release got step=%0d ret=%0d want 0 5", o_dbgStep, o_retired); end
  endtask

  task automatic test_reset_mid_irq();
    finishAt = 5;
    tick();
    i_irq = 1'b1;
    tick();
    i_irq = 1'b0;
    tick(4);
    compared++;
    if (o_irqAck !== 1'b1 || o_instr !== 8'hFF) begin mismatched++; $display("[TB] FAIL midirq_accept got ack=%b instr=%h want 1 FF", o_irqAck, o_instr); end
    tick();
    i_irq = 1'b1;
    tick();
    i_irq = 1'b0;
    tick(2);
    compared++;
    if (o_dbgStep !== 3'd4 || o_instr !== 8'hFF) begin mismatched++; $display("[TB] FAIL midirq_step4 got step=%0d instr=%h want 4 FF", o_dbgStep, o_instr); end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    compared++;
    if (o_decodeAddr !== 15'h0 || o_irqAck !== 1'b0 || o_retired !== 16'd0 || o_fault !== 1'b0) begin mismatched++; $display("[TB] FAIL midirq_reset got addr=%h ack=%b ret=%0d fault=%b want all 0", o_decodeAddr, o_irqAck, o_retired, o_fault); end
    finishAt = 1;
    tick(2);
    compared++;
    if (o_irqAck !== 1'b0 || o_instr !== 8'h34 || o_retired !== 16'd1) begin mismatched++; $display("[TB] FAIL midirq_discard got ack=%b instr=%h ret=%0d want 0 34 1", o_irqAck, o_instr, o_retired); end
  endtask

  task automatic test_fault();
    i_reset = 1'b1;
    finishAt = 8;
    tick();
    i_reset = 1'b0;
    tick(7);
    compared++;
    if (o_dbgStep !== 3'd7 || o_fault !== 1'b0) begin mismatched++; $display("[TB] FAIL fault_step7 got step=%0d fault=%b want 7 0", o_dbgStep, o_fault); end
    tick();
    compared++;
    if (o_fault !== 1'b1 || o_ctrl !== 24'hFFFFFF || o_dbgStep !== 3'd7) begin mismatched++; $display("[TB] FAIL fault_set got fault=%b ctrl=%h step=%0d want 1 FFFFFF 7", o_fault, o_ctrl, o_dbgStep); end
    finishAt = 7;
    i_irq = 1'b1;
    tick();
    i_irq = 1'b0;
    tick(9);
    compared++;
    if (o_fault !== 1'b1 || o_ctrl !== 24'hFFFFFF || o_dbgStep !== 3'd7 || o_retired !== 16'd0 || o_irqAck !== 1'b0) begin mismatched++; $display("[TB] FAIL fault_hold got fault=%b ctrl=%h step=%0d ret=%0d ack=%b want 1 FFFFFF 7 0 0", o_fault, o_ctrl, o_dbgStep, o_retired, o_irqAck); end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    compared++;
    if (o_fault !== 1'b0 || o_ctrl !== RUNW || o_dbgStep !== 3'd0) begin mismatched++; $display("[TB] FAIL fault_clear got fault=%b ctrl=%h step=%0d want 0 %h 0", o_fault, o_ctrl, o_dbgStep, RUNW); end
  endtask

  task automatic test_counter_wrap();
    finishAt = 0;
    tick(65535);
    compared++;
    if (o_retired !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL wrap_max got %h want FFFF", o_retired); end
    tick();
    compared++;
    if (o_retired !== 16'h0000 || o_fault !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_zero got ret=%h fault=%b want 0000 0", o_retired, o_fault); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_irq();
    test_halt();
    test_reset_mid_irq();
    test_fault();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
